// File: rtl/counter_call_dispatcher.sv
// counter_call_dispatcher: queues issued ticket numbers and hands them round-robin to counters pressing "next"
module counter_call_dispatcher #(
  parameter int NUM_W   = 6,
  parameter int N_CNT   = 5,
  parameter int DEPTH   = 16,
  parameter int ANN_CYC = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     issue_valid,
  input  logic [NUM_W-1:0]         issue_number,
  input  logic [N_CNT-1:0]         next_req,
  output logic [N_CNT*NUM_W-1:0]   serving_numbers,
  output logic [N_CNT-1:0]         counter_waiting,
  output logic                     call_valid,
  output logic [2:0]               call_counter,
  output logic [NUM_W-1:0]         call_number,
  output logic                     call_busy,
  output logic [NUM_W-1:0]         max_call_number,
  output logic [$clog2(DEPTH):0]   waiting_count,
  output logic                     queue_overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(ANN_CYC + 1);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam logic [2:0] LAST = 3'(N_CNT - 1);
  localparam logic [TW-1:0] T_LOAD = TW'(ANN_CYC - 1);

  typedef enum logic {IDLE, ANNOUNCE} state_t;

  state_t            state, state_n;
  logic [TW-1:0]     timer, timer_n;
  logic [NUM_W-1:0]  mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [N_CNT-1:0]  prev_req, pending, clear;
  logic [2:0]        rr_ptr, win, idx;
  logic              found, grant, push;

  assign counter_waiting = pending;
  assign call_busy       = (state == ANNOUNCE);
  assign push            = issue_valid && (waiting_count != FULL);
  assign grant           = (state == IDLE) && (waiting_count != '0) && found;
  assign clear           = {{(N_CNT-1){1'b0}}, grant} << win;

  // pick the first pending counter at or after rr_ptr; lower offsets overwrite higher ones
  always_comb begin
    win   = '0;
    found = 1'b0;
    idx   = '0;
    for (int j = N_CNT - 1; j >= 0; j--) begin
      idx = 3'((int'(rr_ptr) + j) % N_CNT);
      if (pending[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

  // a grant opens an announce window of ANN_CYC cycles before the next call
  always_comb begin
    state_n = (state == IDLE) ? (grant ? ANNOUNCE : IDLE) : ((timer == '0) ? IDLE : ANNOUNCE);
    timer_n = grant ? T_LOAD : ((timer == '0) ? timer : timer - 1'b1);
  end

  // FSM state and announce timer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      timer <= '0;
    end else begin
      state <= state_n;
      timer <= timer_n;
    end
  end

  // FIFO storage needs no reset; emptiness is tracked by the pointers and count
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= issue_number;
  end

  // press capture, FIFO bookkeeping and call outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_req        <= '0;
      pending         <= '0;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      waiting_count   <= '0;
      queue_overflow  <= 1'b0;
      rr_ptr          <= '0;
      call_valid      <= 1'b0;
      call_counter    <= '0;
      call_number     <= '0;
      max_call_number <= '0;
      serving_numbers <= '0;
    end else begin
      prev_req      <= next_req;
      pending       <= (pending | (next_req & ~prev_req)) & ~clear;
      waiting_count <= waiting_count + {{AW{1'b0}}, push} - {{AW{1'b0}}, grant};
      call_valid    <= grant;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (issue_valid && !push) queue_overflow <= 1'b1;
      if (grant) begin
        rd_ptr                                  <= rd_ptr + 1'b1;
        rr_ptr                                  <= (win == LAST) ? 3'd0 : win + 3'd1;
        serving_numbers[win*NUM_W +: NUM_W]     <= mem[rd_ptr];
        call_counter                            <= win;
        call_number                             <= mem[rd_ptr];
        max_call_number                         <= mem[rd_ptr];
      end
    end
  end
endmodule

// File: tb/tb_counter_call_dispatcher.sv
// tb_counter_call_dispatcher: scenario tasks plus randomized run against a queue-based reference model
module tb_counter_call_dispatcher;
  localparam int NUM_W = 6, N_CNT = 5, DEPTH = 16, ANN_CYC = 4;

  logic clk = 0, rst = 1, issue_valid = 0;
  logic [NUM_W-1:0] issue_number = 0;
  logic [N_CNT-1:0] next_req = 0;
  logic [N_CNT*NUM_W-1:0] serving_numbers;
  logic [N_CNT-1:0] counter_waiting;
  logic call_valid, call_busy, queue_overflow;
  logic [2:0] call_counter;
  logic [NUM_W-1:0] call_number, max_call_number;
  logic [4:0] waiting_count;
  int errors = 0, checks = 0;

  counter_call_dispatcher #(.NUM_W(NUM_W), .N_CNT(N_CNT), .DEPTH(DEPTH), .ANN_CYC(ANN_CYC)) dut (
    .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_number(issue_number),
    .next_req(next_req), .serving_numbers(serving_numbers), .counter_waiting(counter_waiting),
    .call_valid(call_valid), .call_counter(call_counter), .call_number(call_number),
    .call_busy(call_busy), .max_call_number(max_call_number), .waiting_count(waiting_count),
    .queue_overflow(queue_overflow));

  always #5 clk = ~clk;

  // reference model: ticket queue, pending set, rr pointer, remaining announce cycles
  logic [NUM_W-1:0] mq[$];
  logic [N_CNT-1:0] m_pend, m_prev;
  int m_rr, m_ann;
  logic [N_CNT*NUM_W-1:0] m_serv;
  logic m_cv, m_ovf;
  logic [2:0] m_cc;
  logic [NUM_W-1:0] m_cn, m_max;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete(); m_pend = 0; m_prev = 0; m_rr = 0; m_ann = 0; m_serv = 0;
      m_cv = 0; m_ovf = 0; m_cc = 0; m_cn = 0; m_max = 0;
    end else begin
      int w, sz;
      logic [NUM_W-1:0] head;
      logic [N_CNT-1:0] np;
      sz = mq.size();
      w = -1;
      if (m_ann == 0 && sz > 0)
        for (int j = 0; j < N_CNT; j++)
          if (w < 0 && m_pend[(m_rr + j) % N_CNT]) w = (m_rr + j) % N_CNT;
      np = m_pend | (next_req & ~m_prev);
      m_cv = 0;
      if (m_ann > 0) m_ann--;
      if (w >= 0) begin
        head = mq.pop_front();
        m_serv[w*NUM_W +: NUM_W] = head;
        np[w] = 0;
        m_rr = (w + 1) % N_CNT;
        m_cc = 3'(w); m_cn = head; m_max = head; m_cv = 1; m_ann = ANN_CYC;
      end
      if (issue_valid) begin
        if (sz < DEPTH) mq.push_back(issue_number);
        else m_ovf = 1;
      end
      m_pend = np;
      m_prev = next_req;
    end
  end

  task automatic cyc(input logic iv, input logic [NUM_W-1:0] num, input logic [N_CNT-1:0] req);
    issue_valid = iv; issue_number = num; next_req = req;
    @(negedge clk);
  endtask

  task automatic do_reset();
    issue_valid = 0; next_req = 0; rst = 1;
    @(negedge clk);
    rst = 0;
  endtask

  task automatic test_reset();
    rst = 1; next_req = 5'b00001;
    @(negedge clk);
    checks++; if (serving_numbers !== '0) begin errors++; $display("FAIL reset_serving got %h want 0", serving_numbers); end
    checks++; if (call_valid !== 0 || call_busy !== 0) begin errors++; $display("FAIL reset_call got cv=%b busy=%b want 0 0", call_valid, call_busy); end
    checks++; if (waiting_count !== 0 || queue_overflow !== 0) begin errors++; $display("FAIL reset_fifo got wc=%0d ovf=%b want 0 0", waiting_count, queue_overflow); end
    checks++; if (call_number !== 0 || max_call_number !== 0 || call_counter !== 0 || counter_waiting !== 0) begin errors++; $display("FAIL reset_outs got cn=%0d max=%0d cc=%0d cw=%b want all 0", call_number, max_call_number, call_counter, counter_waiting); end
    rst = 0;
    cyc(0, 0, 5'b00001);
    checks++; if (counter_waiting !== 5'b00001) begin errors++; $display("FAIL held_press got %b want 00001", counter_waiting); end
  endtask

  task automatic test_basic();
    do_reset();
    cyc(1, 1, 0); cyc(1, 2, 0); cyc(1, 3, 0);
    cyc(0, 0, 5'b00001);
    checks++; if (call_valid !== 0 || counter_waiting !== 5'b00001) begin errors++; $display("FAIL basic_press got cv=%b cw=%b want 0 00001", call_valid, counter_waiting); end
    cyc(0, 0, 5'b00001);
    checks++; if (call_valid !== 1 || call_counter !== 0 || call_number !== 1) begin errors++; $display("FAIL basic_call got cv=%b cc=%0d cn=%0d want 1 0 1", call_valid, call_counter, call_number); end
    checks++; if (serving_numbers[0 +: NUM_W] !== 1 || max_call_number !== 1) begin errors++; $display("FAIL basic_show got A=%0d max=%0d want 1 1", serving_numbers[0 +: NUM_W], max_call_number); end
    checks++; if (waiting_count !== 2 || call_busy !== 1 || counter_waiting !== 0) begin errors++; $display("FAIL basic_state got wc=%0d busy=%b cw=%b want 2 1 0", waiting_count, call_busy, counter_waiting); end
    cyc(0, 0, 0);
    checks++; if (call_valid !== 0) begin errors++; $display("FAIL basic_pulse got cv=%b want 0", call_valid); end
  endtask

  task automatic test_multi();
    int k, cnt[4], num[4], at[4];
    do_reset();
    for (int n = 5; n <= 8; n++) cyc(1, 6'(n), 0);
    cyc(0, 0, 5'b01111);
    k = 0;
    for (int t = 1; t <= 40; t++) begin
      cyc(0, 0, 0);
      if (call_valid && k < 4) begin cnt[k] = call_counter; num[k] = call_number; at[k] = t; k++; end
    end
    checks++; if (k !== 4) begin errors++; $display("FAIL multi_count got %0d calls want 4", k); end
    for (int i = 0; i < k; i++) begin
      checks++; if (cnt[i] !== i || num[i] !== 5 + i) begin errors++; $display("FAIL multi_call%0d got cnt=%0d num=%0d want %0d %0d", i, cnt[i], num[i], i, 5 + i); end
      checks++; if (at[i] !== 1 + i * (ANN_CYC + 1)) begin errors++; $display("FAIL multi_time%0d got %0d want %0d", i, at[i], 1 + i * (ANN_CYC + 1)); end
    end
    checks++; if (serving_numbers !== {6'd0, 6'd8, 6'd7, 6'd6, 6'd5}) begin errors++; $display("FAIL multi_serving got %h want %h", serving_numbers, {6'd0, 6'd8, 6'd7, 6'd6, 6'd5}); end
  endtask

  task automatic test_rr();
    int k, cnt[2], num[2];
    do_reset();
    cyc(1, 10, 0); cyc(1, 11, 0); cyc(1, 12, 0);
    cyc(0, 0, 5'b00100);
    cyc(0, 0, 0);
    checks++; if (call_valid !== 1 || call_counter !== 2 || call_number !== 10) begin errors++; $display("FAIL rr_c got cv=%b cc=%0d cn=%0d want 1 2 10", call_valid, call_counter, call_number); end
    for (int t = 0; t < 10 && call_busy; t++) cyc(0, 0, 0);
    checks++; if (call_busy !== 0) begin errors++; $display("FAIL rr_idle got busy=%b want 0", call_busy); end
    cyc(0, 0, 5'b01001);
    k = 0;
    for (int t = 0; t < 20; t++) begin
      cyc(0, 0, 0);
      if (call_valid && k < 2) begin cnt[k] = call_counter; num[k] = call_number; k++; end
    end
    checks++; if (k !== 2) begin errors++; $display("FAIL rr_count got %0d calls want 2", k); end
    checks++; if (k > 0 && (cnt[0] !== 3 || num[0] !== 11)) begin errors++; $display("FAIL rr_first got cnt=%0d num=%0d want 3 11", cnt[0], num[0]); end
    checks++; if (k > 1 && (cnt[1] !== 0 || num[1] !== 12)) begin errors++; $display("FAIL rr_second got cnt=%0d num=%0d want 0 12", cnt[1], num[1]); end
  endtask

  task automatic test_empty();
    int seen;
    do_reset();
    seen = 0;
    for (int t = 0; t < 6; t++) begin cyc(0, 0, 5'b10000); seen += int'(call_valid); end
    checks++; if (counter_waiting !== 5'b10000 || seen !== 0) begin errors++; $display("FAIL empty_wait got cw=%b calls=%0d want 10000 0", counter_waiting, seen); end
    cyc(1, 9, 0);
    checks++; if (call_valid !== 0 || serving_numbers[4*NUM_W +: NUM_W] !== 0 || waiting_count !== 1) begin errors++; $display("FAIL empty_push got cv=%b E=%0d wc=%0d want 0 0 1", call_valid, serving_numbers[4*NUM_W +: NUM_W], waiting_count); end
    cyc(0, 0, 0);
    checks++; if (call_valid !== 1 || call_counter !== 4 || serving_numbers[4*NUM_W +: NUM_W] !== 9) begin errors++; $display("FAIL empty_call got cv=%b cc=%0d E=%0d want 1 4 9", call_valid, call_counter, serving_numbers[4*NUM_W +: NUM_W]); end
    checks++; if (counter_waiting !== 0 || waiting_count !== 0) begin errors++; $display("FAIL empty_after got cw=%b wc=%0d want 0 0", counter_waiting, waiting_count); end
  endtask

  task automatic test_overflow();
    bit got;
    int seen;
    do_reset();
    for (int n = 0; n < 17; n++) cyc(1, 6'(20 + n), 0);
    checks++; if (waiting_count !== 16 || queue_overflow !== 1) begin errors++; $display("FAIL ovf_full got wc=%0d ovf=%b want 16 1", waiting_count, queue_overflow); end
    cyc(0, 0, 5'b00001);
    cyc(1, 50, 0);
    checks++; if (call_valid !== 1 || call_number !== 20 || waiting_count !== 15) begin errors++; $display("FAIL ovf_popdrop got cv=%b cn=%0d wc=%0d want 1 20 15", call_valid, call_number, waiting_count); end
    for (int n = 1; n < 16; n++) begin
      cyc(0, 0, 5'b00001);
      got = 0;
      for (int t = 0; t < 12 && !got; t++) begin cyc(0, 0, 0); got = call_valid; end
      checks++; if (!got || call_number !== 6'(20 + n)) begin errors++; $display("FAIL ovf_drain%0d got valid=%b num=%0d want 1 %0d", n, got, call_number, 20 + n); end
    end
    cyc(0, 0, 5'b00001);
    seen = 0;
    for (int t = 0; t < 10; t++) begin cyc(0, 0, 0); seen += int'(call_valid); end
    checks++; if (seen !== 0 || waiting_count !== 0 || queue_overflow !== 1 || counter_waiting !== 5'b00001) begin errors++; $display("FAIL ovf_end got calls=%0d wc=%0d ovf=%b cw=%b want 0 0 1 00001", seen, waiting_count, queue_overflow, counter_waiting); end
  endtask

  task automatic test_reset_mid();
    int seen;
    do_reset();
    for (int n = 1; n <= 4; n++) cyc(1, 6'(n), 0);
    cyc(0, 0, 5'b00010);
    cyc(0, 0, 0);
    checks++; if (call_valid !== 1 || call_counter !== 1 || call_busy !== 1 || waiting_count !== 3) begin errors++; $display("FAIL mid_call got cv=%b cc=%0d busy=%b wc=%0d want 1 1 1 3", call_valid, call_counter, call_busy, waiting_count); end
    cyc(0, 0, 0);
    #2 rst = 1;
    #1;
    checks++; if (serving_numbers !== 0 || call_busy !== 0 || waiting_count !== 0 || max_call_number !== 0 || call_number !== 0 || call_counter !== 0 || call_valid !== 0) begin errors++; $display("FAIL mid_async got serv=%h busy=%b wc=%0d max=%0d cn=%0d cc=%0d cv=%b want all 0", serving_numbers, call_busy, waiting_count, max_call_number, call_number, call_counter, call_valid); end
    @(negedge clk);
    rst = 0;
    cyc(0, 0, 5'b00100);
    seen = 0;
    for (int t = 0; t < 8; t++) begin cyc(0, 0, 0); seen += int'(call_valid); end
    checks++; if (seen !== 0 || counter_waiting !== 5'b00100) begin errors++; $display("FAIL mid_lost got calls=%0d cw=%b want 0 00100", seen, counter_waiting); end
    cyc(1, 7, 0);
    cyc(0, 0, 0);
    checks++; if (call_valid !== 1 || call_counter !== 2 || call_number !== 7) begin errors++; $display("FAIL mid_new got cv=%b cc=%0d cn=%0d want 1 2 7", call_valid, call_counter, call_number); end
  endtask

  task automatic test_random();
    logic [N_CNT-1:0] req;
    logic iv;
    do_reset();
    req = 0;
    for (int t = 0; t < 500; t++) begin
      iv = (t < 200) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 5) == 0);
      req = req ^ 5'($urandom & $urandom);
      cyc(iv, 6'($urandom), req);
      checks++; if (call_valid !== m_cv || call_counter !== m_cc || call_number !== m_cn || max_call_number !== m_max) begin errors++; $display("FAIL rnd_call t=%0d got cv=%b cc=%0d cn=%0d max=%0d want %b %0d %0d %0d", t, call_valid, call_counter, call_number, max_call_number, m_cv, m_cc, m_cn, m_max); end
      checks++; if (serving_numbers !== m_serv) begin errors++; $display("FAIL rnd_serving t=%0d got %h want %h", t, serving_numbers, m_serv); end
      checks++; if (counter_waiting !== m_pend || call_busy !== (m_ann > 0)) begin errors++; $display("FAIL rnd_pend t=%0d got cw=%b busy=%b want %b %b", t, counter_waiting, call_busy, m_pend, m_ann > 0); end
      checks++; if (waiting_count !== 5'(mq.size()) || queue_overflow !== m_ovf) begin errors++; $display("FAIL rnd_fifo t=%0d got wc=%0d ovf=%b want %0d %b", t, waiting_count, queue_overflow, mq.size(), m_ovf); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_multi();
    test_rr();
    test_empty();
    test_overflow();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
